// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier (mul_iter / mul_pp_gen).
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROD = 2'd1,
        SUM  = 2'd2
    } mul_state_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_ADD  = 2'b01,
        ACC_SUB  = 2'b10
    } acc_op_e;

endpackage

// File: rtl/mul_pp_gen.sv
// Combinational generator of the four HALF x HALF partial products of two
// unsigned WIDTH-bit magnitudes; each product is zero-extended to WIDTH bits.
module mul_pp_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_abs,
    input  logic [WIDTH-1:0] b_abs,
    output logic [WIDTH-1:0] pp0,
    output logic [WIDTH-1:0] pp1,
    output logic [WIDTH-1:0] pp2,
    output logic [WIDTH-1:0] pp3
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] a_lo_s;
    logic [WIDTH-1:0] a_hi_s;
    logic [WIDTH-1:0] b_lo_s;
    logic [WIDTH-1:0] b_hi_s;

    // Widen each half before multiplying so the product cannot truncate
    assign a_lo_s = {{HALF{1'b0}}, a_abs[HALF-1:0]};
    assign a_hi_s = {{HALF{1'b0}}, a_abs[WIDTH-1:HALF]};
    assign b_lo_s = {{HALF{1'b0}}, b_abs[HALF-1:0]};
    assign b_hi_s = {{HALF{1'b0}}, b_abs[WIDTH-1:HALF]};

    assign pp0 = a_lo_s * b_lo_s;
    assign pp1 = a_lo_s * b_hi_s;
    assign pp2 = a_hi_s * b_lo_s;
    assign pp3 = a_hi_s * b_hi_s;

endmodule

// File: rtl/mul_iter.sv
// Handshaked three-state multiplier: IDLE captures partial products, PROD sums
// and sign-corrects them, SUM pulses ready. Optional accumulate via MUL_ACC_EN.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sign,
    input  logic                 start,
    input  logic                 flush,
`ifdef MUL_ACC_EN
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [1:0]           acc_op,
`endif
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int HALF = WIDTH / 2;

    mul_state_e         state_q, state_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               sign_q, sign_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   pp0_q, pp0_d;
    logic [WIDTH-1:0]   pp1_q, pp1_d;
    logic [WIDTH-1:0]   pp2_q, pp2_d;
    logic [WIDTH-1:0]   pp3_q, pp3_d;
`ifdef MUL_ACC_EN
    logic [2*WIDTH-1:0] acc_in_q, acc_in_d;
    acc_op_e            acc_op_q, acc_op_d;
`endif

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [WIDTH-1:0]   pp0_s, pp1_s, pp2_s, pp3_s;
    logic [2*WIDTH-1:0] mid_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] final_s;

    // Operand magnitudes; the most negative value maps to itself as unsigned
    always_comb begin
        a_neg_s = sign & a[WIDTH-1];
        b_neg_s = sign & b[WIDTH-1];
        if (a_neg_s) begin
            a_abs_s = -a;
        end else begin
            a_abs_s = a;
        end
        if (b_neg_s) begin
            b_abs_s = -b;
        end else begin
            b_abs_s = b;
        end
    end

    mul_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .a_abs (a_abs_s),
        .b_abs (b_abs_s),
        .pp0   (pp0_s),
        .pp1   (pp1_s),
        .pp2   (pp2_s),
        .pp3   (pp3_s)
    );

    // Recombine registered partial products, restore sign, apply accumulate
    always_comb begin
        mid_s = {{WIDTH{1'b0}}, pp0_q}
              + {{HALF{1'b0}}, pp1_q, {HALF{1'b0}}}
              + {{HALF{1'b0}}, pp2_q, {HALF{1'b0}}}
              + {pp3_q, {WIDTH{1'b0}}};
        if (sign_q && (a_neg_q ^ b_neg_q)) begin
            prod_s = -mid_s;
        end else begin
            prod_s = mid_s;
        end
`ifdef MUL_ACC_EN
        case (acc_op_q)
            ACC_ADD: final_s = acc_in_q + prod_s;
            ACC_SUB: final_s = acc_in_q - prod_s;
            default: final_s = prod_s;
        endcase
`else
        final_s = prod_s;
`endif
    end

    // Next-state logic; flush overrides everything, including a same-cycle start
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        result_d = result_q;
        sign_d   = sign_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        pp0_d    = pp0_q;
        pp1_d    = pp1_q;
        pp2_d    = pp2_q;
        pp3_d    = pp3_q;
`ifdef MUL_ACC_EN
        acc_in_d = acc_in_q;
        acc_op_d = acc_op_q;
`endif
        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_d  = sign;
                        a_neg_d = a_neg_s;
                        b_neg_d = b_neg_s;
                        pp0_d   = pp0_s;
                        pp1_d   = pp1_s;
                        pp2_d   = pp2_s;
                        pp3_d   = pp3_s;
`ifdef MUL_ACC_EN
                        acc_in_d = acc_in;
                        acc_op_d = acc_op_e'(acc_op);
`endif
                        state_d = PROD;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                PROD: begin
                    result_d = final_s;
                    ready_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SUM;
                end
                SUM: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
            sign_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            pp0_q    <= {WIDTH{1'b0}};
            pp1_q    <= {WIDTH{1'b0}};
            pp2_q    <= {WIDTH{1'b0}};
            pp3_q    <= {WIDTH{1'b0}};
`ifdef MUL_ACC_EN
            acc_in_q <= {(2*WIDTH){1'b0}};
            acc_op_q <= ACC_NONE;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            pp0_q    <= pp0_d;
            pp1_q    <= pp1_d;
            pp2_q    <= pp2_d;
            pp3_q    <= pp3_d;
`ifdef MUL_ACC_EN
            acc_in_q <= acc_in_d;
            acc_op_q <= acc_op_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = result_q;

endmodule
